// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// FSM encoding, wait-counter width and data width.
package dmem_pkg;

  localparam int DMEM_DATA_W = 16;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_if.sv
// STB/WE/ACK data-bus bundle between the CPU data port and the responder.
// ERR_O only exists when DMEM_ERR_EN is defined.
interface dmem_if;
  import dmem_pkg::*;

  logic                   STB_I;
  logic                   WE_I;
  logic [15:0]            ADR_I;
  logic [DMEM_DATA_W-1:0] DAT_I;
  logic [DMEM_DATA_W-1:0] DAT_O;
  logic                   ACK_O;

`ifdef DMEM_ERR_EN
  logic                   ERR_O;

  modport slave  (input  STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O, ERR_O);
  modport master (output STB_I, WE_I, ADR_I, DAT_I, input  DAT_O, ACK_O, ERR_O);
`else
  modport slave  (input  STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O);
  modport master (output STB_I, WE_I, ADR_I, DAT_I, input  DAT_O, ACK_O);
`endif

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM with registered read data.
// The read register resets/clears to zero; the array itself is never cleared.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   en,
  input  logic                   we,
  input  logic                   clr,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DMEM_DATA_W-1:0] rdata_reg;

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read data only moves on a completed read, so writes leave it untouched.
  always_ff @(posedge clk) begin
    if (srst || clr) begin
      rdata_reg <= '0;
    end else if (en && !we) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: one registered request, WAIT_CYCLES wait states, one-cycle ACK.
// Define DMEM_ERR_EN to report out-of-range addresses on ERR_O instead of wrapping.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic   CLK_I,
  input  logic   RST_I,
  dmem_if.slave  bus
);

  localparam logic [DMEM_CNT_W-1:0] WAIT_INIT = DMEM_CNT_W'(WAIT_CYCLES);
  localparam logic [DMEM_CNT_W-1:0] CNT_ONE   = DMEM_CNT_W'(1);

  dmem_state_e            state_reg;
  logic [DMEM_CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic                   we_reg;
  logic [DMEM_DATA_W-1:0] wdata_reg;
  logic                   oor_reg;
  logic                   ack_reg;

  logic                   req_oor;
  logic                   go_resp;
  logic [ADDR_W-1:0]      cur_addr;
  logic                   cur_we;
  logic [DMEM_DATA_W-1:0] cur_wdata;
  logic                   cur_oor;
  logic                   ram_en;
  logic                   ram_clr;

`ifdef DMEM_ERR_EN
  logic err_reg;
  assign req_oor    = |bus.ADR_I[15:ADDR_W];
  assign bus.ERR_O  = err_reg;
`else
  assign req_oor    = 1'b0;
`endif

  // In IDLE the RAM sees the live bus so a zero-wait request completes on its capture edge.
  always_comb begin
    cur_addr  = addr_reg;
    cur_we    = we_reg;
    cur_wdata = wdata_reg;
    cur_oor   = oor_reg;
    go_resp   = 1'b0;
    if (state_reg == IDLE) begin
      cur_addr  = bus.ADR_I[ADDR_W-1:0];
      cur_we    = bus.WE_I;
      cur_wdata = bus.DAT_I;
      cur_oor   = req_oor;
    end
    case (state_reg)
      IDLE:    go_resp = bus.STB_I && (WAIT_CYCLES == 0);
      WAIT:    go_resp = bus.STB_I && (cnt_reg == CNT_ONE);
      default: go_resp = 1'b0;
    endcase
    ram_en  = go_resp && !RST_I && !cur_oor;
    ram_clr = go_resp && !RST_I && cur_oor && !cur_we;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      oor_reg   <= 1'b0;
      ack_reg   <= 1'b0;
`ifdef DMEM_ERR_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      ack_reg <= 1'b0;
`ifdef DMEM_ERR_EN
      err_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (bus.STB_I) begin
            addr_reg  <= bus.ADR_I[ADDR_W-1:0];
            we_reg    <= bus.WE_I;
            wdata_reg <= bus.DAT_I;
            oor_reg   <= req_oor;
            cnt_reg   <= WAIT_INIT;
            if (go_resp) begin
              state_reg <= RESP;
              ack_reg   <= !req_oor;
`ifdef DMEM_ERR_EN
              err_reg   <= req_oor;
`endif
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (!bus.STB_I) begin
            state_reg <= IDLE;
          end else if (go_resp) begin
            state_reg <= RESP;
            ack_reg   <= !oor_reg;
`ifdef DMEM_ERR_EN
            err_reg   <= oor_reg;
`endif
          end
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ACK_O = ack_reg;

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (CLK_I),
    .srst  (RST_I),
    .en    (ram_en),
    .we    (cur_we),
    .clr   (ram_clr),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rdata (bus.DAT_O)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder with WAIT_CYCLES = 1, 0 and 3 instances.
// Build with or without DMEM_ERR_EN; out-of-range expectations follow the macro.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        stb [3];
  logic        we  [3];
  logic        rst [3];
  logic [15:0] adr [3];
  logic [15:0] wd  [3];
  logic        ack [3];
  logic        err [3];
  logic [15:0] rd  [3];

  dmem_if bus0 ();
  dmem_if bus1 ();
  dmem_if bus2 ();

  assign bus0.STB_I = stb[0]; assign bus0.WE_I = we[0]; assign bus0.ADR_I = adr[0]; assign bus0.DAT_I = wd[0];
  assign bus1.STB_I = stb[1]; assign bus1.WE_I = we[1]; assign bus1.ADR_I = adr[1]; assign bus1.DAT_I = wd[1];
  assign bus2.STB_I = stb[2]; assign bus2.WE_I = we[2]; assign bus2.ADR_I = adr[2]; assign bus2.DAT_I = wd[2];
  assign ack[0] = bus0.ACK_O; assign rd[0] = bus0.DAT_O;
  assign ack[1] = bus1.ACK_O; assign rd[1] = bus1.DAT_O;
  assign ack[2] = bus2.ACK_O; assign rd[2] = bus2.DAT_O;
`ifdef DMEM_ERR_EN
  assign err[0] = bus0.ERR_O; assign err[1] = bus1.ERR_O; assign err[2] = bus2.ERR_O;
`else
  assign err[0] = 1'b0; assign err[1] = 1'b0; assign err[2] = 1'b0;
`endif

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u0 (.CLK_I(clk), .RST_I(rst[0]), .bus(bus0));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u1 (.CLK_I(clk), .RST_I(rst[1]), .bus(bus1));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u2 (.CLK_I(clk), .RST_I(rst[2]), .bus(bus2));

  typedef struct {
    int          dut;
    logic        is_err;
    logic [15:0] dat;
    int          lat;
    int          issue_cyc;
  } exp_t;

  exp_t        sbq [$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] last_rd [3];
  int          lat_tab [3] = '{2, 1, 4};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ack[d] || err[d]) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp dut%0d: got ack=%b err=%b dat=%h expected no response",
                   d, ack[d], err[d], rd[d]);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (e.dut != d || (ack[d] && err[d]) || err[d] != e.is_err ||
              rd[d] !== e.dat || (cyc - e.issue_cyc) != e.lat) begin
            bad++;
            $display("FAIL resp dut%0d: got err=%b dat=%h lat=%0d expected dut%0d err=%b dat=%h lat=%0d",
                     d, err[d], rd[d], cyc - e.issue_cyc, e.dut, e.is_err, e.dat, e.lat);
          end else begin
            $display("resp dut%0d %s dat=%h lat=%0d ok", d, err[d] ? "err" : "ack", rd[d], e.lat);
          end
        end
      end
    end
  end

  // Call at posedge+1; holds STB until a response, then releases it after the RESP edge.
  task automatic xfer(input int d, input logic w, input logic [15:0] a, input logic [15:0] data,
                      input logic exp_err, input logic [15:0] exp_rd);
    exp_t e;
    int   n;
    e.dut       = d;
    e.is_err    = exp_err;
    e.lat       = lat_tab[d];
    e.issue_cyc = cyc;
    if (w) begin
      e.dat = last_rd[d];
    end else begin
      e.dat      = exp_rd;
      last_rd[d] = exp_rd;
    end
    sbq.push_back(e);
    stb[d] = 1'b1; we[d] = w; adr[d] = a; wd[d] = data;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack[d] || err[d]) && n < 30);
    if (n >= 30) begin
      total++;
      bad++;
      $display("FAIL timeout dut%0d addr=%h: got no response expected one within 30 cycles", d, a);
      void'(sbq.pop_front());
    end
    @(posedge clk);
    #1;
    stb[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      stb[d] = 1'b0; we[d] = 1'b0; rst[d] = 1'b1; adr[d] = '0; wd[d] = '0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ack%0d", d), 32'(ack[d]), 32'h0);
      chk($sformatf("reset_err%0d", d), 32'(err[d]), 32'h0);
      chk($sformatf("reset_dat%0d", d), 32'(rd[d]), 32'h0);
    end
    chk("reset_state0", 32'(u0.state_reg), 32'(IDLE));
    @(posedge clk);
    #1;

    // One wait state: write then read back.
    xfer(0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0);
    xfer(0, 1'b0, 16'h0005, 16'h0,    1'b0, 16'hBEEF);

    // Zero wait states, back to back at the top word.
    xfer(1, 1'b1, 16'h03FF, 16'h1234, 1'b0, 16'h0);
    xfer(1, 1'b0, 16'h03FF, 16'h0,    1'b0, 16'h1234);

    // Three wait states: abort in the second wait cycle.
    xfer(2, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0);
    xfer(2, 1'b0, 16'h0020, 16'h0,    1'b0, 16'h1111);
    stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 16'h0020; wd[2] = 16'h2222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb[2] = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle", 32'(u2.state_reg), 32'(IDLE));
    repeat (5) @(posedge clk);
    #1;
    xfer(2, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h1111);

    // Reset while a write sits in WAIT with STB still asserted.
    xfer(0, 1'b1, 16'h0010, 16'h7777, 1'b0, 16'h0);
    xfer(0, 1'b0, 16'h0010, 16'h0,    1'b0, 16'h7777);
    stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 16'h0010; wd[0] = 16'hAAAA;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0; stb[0] = 1'b0;
    last_rd[0] = 16'h0;
    @(negedge clk);
    chk("rst_mid_ack", 32'(ack[0]), 32'h0);
    chk("rst_mid_dat", 32'(rd[0]), 32'h0);
    chk("rst_mid_state", 32'(u0.state_reg), 32'(IDLE));
    @(posedge clk); #1;
    xfer(0, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h7777);

    // Out-of-range address 0x0400.
    xfer(0, 1'b1, 16'h0000, 16'h0ABC, 1'b0, 16'h0);
`ifdef DMEM_ERR_EN
    xfer(0, 1'b1, 16'h0400, 16'h5A5A, 1'b1, 16'h0);
    xfer(0, 1'b0, 16'h0000, 16'h0,    1'b0, 16'h0ABC);
    xfer(0, 1'b0, 16'h0400, 16'h0,    1'b1, 16'h0000);
`else
    xfer(0, 1'b1, 16'h0400, 16'h5A5A, 1'b0, 16'h0);
    xfer(0, 1'b0, 16'h0000, 16'h0,    1'b0, 16'h5A5A);
    xfer(0, 1'b0, 16'h0400, 16'h0,    1'b0, 16'h5A5A);
`endif

    // DAT_O holds the last read across a write's ACK.
    xfer(0, 1'b0, 16'h0005, 16'h0,    1'b0, 16'hBEEF);
    xfer(0, 1'b1, 16'h0000, 16'h5555, 1'b0, 16'h0);
    xfer(0, 1'b0, 16'h0000, 16'h0,    1'b0, 16'h5555);

    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
